prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed byte stream from the host link
// and writes 32-bit instruction words into the core's instruction memory.
module prog_loader #(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t              state_q;
    logic                rdy_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                crst_q;
    logic                done_q;
    logic                err_q;
    logic [7:0]          chk_q;
    logic [15:0]         cnt_q;
    logic [16:0]         widx_q;
    logic [1:0]          lane_q;
    logic [23:0]         word_q;

    logic                acc;
    logic [15:0]         cnt_w;
    logic [16:0]         widx_nx;

    assign acc     = rx_valid & rdy_q;
    assign cnt_w   = {rx_data, cnt_q[7:0]};
    assign widx_nx = widx_q + 17'd1;

    assign rx_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = crst_q;
    assign done       = done_q;
    assign error      = err_q;

    // Frame parser FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            chk_q   <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            lane_q  <= '0;
            word_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            we_q  <= 1'b0;
            if (acc) begin
                case (state_q)
                    IDLE, DONE, ERR: begin
                        // Only MAGIC starts a frame; anything else is dropped.
                        if (rx_data == MAGIC) begin
                            state_q <= CNT_LO;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            chk_q   <= '0;
                            widx_q  <= '0;
                            lane_q  <= '0;
                            crst_q  <= 1'b1;
                        end
                    end
                    CNT_LO: begin
                        cnt_q[7:0] <= rx_data;
                        chk_q      <= chk_q ^ rx_data;
                        state_q    <= CNT_HI;
                    end
                    CNT_HI: begin
                        cnt_q[15:8] <= rx_data;
                        chk_q       <= chk_q ^ rx_data;
                        if (cnt_w == 16'd0 || {1'b0, cnt_w} > MAX_WORDS) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        chk_q  <= chk_q ^ rx_data;
                        lane_q <= lane_q + 2'd1;
                        case (lane_q)
                            2'd0: word_q[7:0]   <= rx_data;
                            2'd1: word_q[15:8]  <= rx_data;
                            2'd2: word_q[23:16] <= rx_data;
                            default: begin
                                we_q    <= 1'b1;
                                addr_q  <= widx_q[ADDR_W-1:0];
                                wdata_q <= {rx_data, word_q};
                                widx_q  <= widx_nx;
                                if (widx_nx == {1'b0, cnt_q}) begin
                                    state_q <= CHK;
                                end
                            end
                        endcase
                    end
                    CHK: begin
                        if (rx_data == chk_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            crst_q  <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
